// File: rtl/acc_demo_flag_tx_drv_pkg.sv
// acc_demo_flag_tx_drv_pkg: sync word constants and serialiser state type shared by the flag link blocks
package acc_demo_flag_tx_drv_pkg;

    localparam logic [15:0] SYNC_ACC1      = 16'hACC1;
    localparam logic [15:0] SYNC_ACC0      = 16'hACC0;
    localparam logic [15:0] SYNC_SCAN_RUN  = 16'h5A51;
    localparam logic [15:0] SYNC_SCAN_TEST = 16'h5A53;
    localparam logic [15:0] SYNC_SCAN_OFF  = 16'h5A50;

    typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SHIFT, TX_GAP} tx_state_e;

    function automatic logic [15:0] scan_word(input logic start, input logic test);
        return !start ? SYNC_SCAN_OFF : test ? SYNC_SCAN_TEST : SYNC_SCAN_RUN;
    endfunction

endpackage

// File: rtl/acc_demo_flag_tx_drv_serial_tx.sv
// acc_demo_flag_tx_drv_serial_tx: word serialiser, MSB beat first, data changes on falling serial clock
module acc_demo_flag_tx_drv_serial_tx
    import acc_demo_flag_tx_drv_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int SERIAL_MODE = 1,
    parameter int CLK_DIV     = 4,
    parameter int IDLE_GAP    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   tx_valid_i,
    input  logic                   tx_chain_i,
    input  logic [DATA_WIDTH-1:0]  tx_data_i,
    output logic                   tx_ready_o,
    output logic                   tx_busy_o,
    output logic                   TX_CLK,
    output logic [SERIAL_MODE-1:0] TX_DOUT
);

    localparam int BEATS  = DATA_WIDTH / SERIAL_MODE;
    localparam int DIV_W  = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BEAT_W = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int GAP_W  = IDLE_GAP > 1 ? $clog2(IDLE_GAP) : 1;

    if (DATA_WIDTH % SERIAL_MODE != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of SERIAL_MODE");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("CLK_DIV must be at least 1");
    end
    if (IDLE_GAP < 1) begin : g_bad_gap
        $error("IDLE_GAP must be at least 1");
    end

    tx_state_e              state_q;
    logic [DATA_WIDTH-1:0]  shreg_q;
    logic [DIV_W-1:0]       div_q;
    logic [BEAT_W-1:0]      beat_q;
    logic [GAP_W-1:0]       gap_q;
    logic                   clk_q;
    logic [SERIAL_MODE-1:0] dout_q;
    logic                   div_end, gap_end, beat_last, fire;

    assign div_end    = div_q == DIV_W'(CLK_DIV - 1);
    assign gap_end    = gap_q == GAP_W'(IDLE_GAP - 1);
    assign beat_last  = beat_q == BEAT_W'(BEATS - 1);
    // a chained word may start in the last gap cycle so the pair goes out back to back
    assign tx_ready_o = state_q == TX_IDLE || (state_q == TX_GAP && gap_end && tx_chain_i);
    assign fire       = tx_valid_i && tx_ready_o;
    assign tx_busy_o  = state_q != TX_IDLE;
    assign TX_CLK     = clk_q;
    assign TX_DOUT    = dout_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= TX_IDLE;
            shreg_q <= '0;
            div_q   <= '0;
            beat_q  <= '0;
            gap_q   <= '0;
            clk_q   <= 1'b0;
            dout_q  <= '0;
        end else if (fire) begin
            state_q <= TX_LOAD;
            shreg_q <= tx_data_i << SERIAL_MODE;
            dout_q  <= tx_data_i[DATA_WIDTH-1 -: SERIAL_MODE];
            clk_q   <= 1'b0;
        end else begin
            case (state_q)
                TX_LOAD: begin
                    state_q <= TX_SHIFT;
                    div_q   <= '0;
                    beat_q  <= '0;
                end
                TX_SHIFT: begin
                    div_q <= div_end ? '0 : div_q + 1'b1;
                    if (div_end) begin
                        clk_q <= !clk_q;
                        if (clk_q) begin
                            beat_q  <= beat_q + 1'b1;
                            shreg_q <= shreg_q << SERIAL_MODE;
                            dout_q  <= beat_last ? '0 : shreg_q[DATA_WIDTH-1 -: SERIAL_MODE];
                            if (beat_last) begin
                                state_q <= TX_GAP;
                                gap_q   <= '0;
                            end
                        end
                    end
                end
                TX_GAP: begin
                    gap_q <= gap_q + 1'b1;
                    if (gap_end) state_q <= TX_IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/acc_demo_flag_tx_drv.sv
// acc_demo_flag_tx_drv: encodes acc/scan level changes as sync words and sends them over the serial link
module acc_demo_flag_tx_drv
    import acc_demo_flag_tx_drv_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int SERIAL_MODE    = 1,
    parameter int CLK_DIV        = 4,
    parameter int IDLE_GAP       = 8,
    parameter int REFRESH_CYCLES = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   acc_demo_flag_i,
    input  logic                   scan_start_i,
    input  logic                   scan_test_i,
    output logic                   tx_busy_o,
    output logic                   SPI_MCLK,
    output logic [SERIAL_MODE-1:0] SPI_MOSI
);

    localparam int REF_W = REFRESH_CYCLES > 0 ? $clog2(REFRESH_CYCLES + 1) : 1;

    logic [DATA_WIDTH-1:0] last_acc_q, last_scan_q, acc_word, scan_word_w, tx_data;
    logic [REF_W-1:0]      ref_cnt_q;
    logic                  ref_scan_q;
    logic                  pend_acc, pend_scan, ref_due, sel_scan, tx_valid, tx_ready, fire;

    // pending is a level compare against the last word sent, so reverted pulses coalesce away
    assign acc_word    = DATA_WIDTH'(acc_demo_flag_i ? SYNC_ACC1 : SYNC_ACC0);
    assign scan_word_w = DATA_WIDTH'(scan_word(scan_start_i, scan_test_i));
    assign pend_acc    = acc_word != last_acc_q;
    assign pend_scan   = scan_word_w != last_scan_q;
    assign ref_due     = REFRESH_CYCLES != 0 && ref_cnt_q == REF_W'(REFRESH_CYCLES);
    assign sel_scan    = ref_scan_q || (!pend_acc && pend_scan);
    assign tx_valid    = ref_scan_q || pend_acc || pend_scan || ref_due;
    assign tx_data     = sel_scan ? scan_word_w : acc_word;
    assign fire        = tx_valid && tx_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_acc_q  <= DATA_WIDTH'(SYNC_ACC0);
            last_scan_q <= DATA_WIDTH'(SYNC_SCAN_OFF);
            ref_cnt_q   <= '0;
            ref_scan_q  <= 1'b0;
        end else begin
            if (fire && sel_scan) last_scan_q <= scan_word_w;
            if (fire && !sel_scan) last_acc_q <= acc_word;
            ref_scan_q <= fire ? ref_due && !pend_acc && !pend_scan && !ref_scan_q : ref_scan_q;
            ref_cnt_q  <= fire ? '0 : (tx_ready && REFRESH_CYCLES != 0) ? ref_cnt_q + 1'b1 : ref_cnt_q;
        end
    end

    acc_demo_flag_tx_drv_serial_tx #(
        .DATA_WIDTH (DATA_WIDTH),
        .SERIAL_MODE(SERIAL_MODE),
        .CLK_DIV    (CLK_DIV),
        .IDLE_GAP   (IDLE_GAP)
    ) u_serial_tx (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .tx_valid_i(tx_valid),
        .tx_chain_i(ref_scan_q),
        .tx_data_i (tx_data),
        .tx_ready_o(tx_ready),
        .tx_busy_o (tx_busy_o),
        .TX_CLK    (SPI_MCLK),
        .TX_DOUT   (SPI_MOSI)
    );

endmodule
